// File: rtl/updown_counter_lim.sv
// Loadable up/down counter with programmable bounds and step.
// Wraps or saturates at the bounds and reports terminal count plus overflow/underflow pulses.
module updown_counter_lim #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SAT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             updown,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] lo_limit,
  input  logic [WIDTH-1:0] hi_limit,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_count_d;
  logic             w_ovf_d;
  logic             w_unf_d;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_lo_plus_step;
  logic [WIDTH-1:0] w_diff;
  logic             w_over;
  logic             w_under;

  // Compares carry one extra bit so a large step never aliases back into range.
  assign w_sum          = {1'b0, r_count} + {1'b0, step};
  assign w_lo_plus_step = {1'b0, lo_limit} + {1'b0, step};
  assign w_diff         = r_count - step;
  assign w_over         = w_sum > {1'b0, hi_limit};
  assign w_under        = {1'b0, r_count} < w_lo_plus_step;

  always_comb begin
    w_count_d = r_count;
    w_ovf_d   = 1'b0;
    w_unf_d   = 1'b0;
    if (load) begin
      w_count_d = data;
    end else if (en) begin
      if (updown) begin
        if (w_over) begin
          w_count_d = SAT_MODE ? hi_limit : lo_limit;
          w_ovf_d   = 1'b1;
        end else begin
          w_count_d = w_sum[WIDTH-1:0];
        end
      end else begin
        if (w_under) begin
          w_count_d = SAT_MODE ? lo_limit : hi_limit;
          w_unf_d   = 1'b1;
        end else begin
          w_count_d = w_diff;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_d;
      r_ovf   <= w_ovf_d;
      r_unf   <= w_unf_d;
    end
  end

  assign data_out = r_count;
  assign ovf      = r_ovf;
  assign unf      = r_unf;
  assign tc       = updown ? (r_count >= hi_limit) : (r_count <= lo_limit);

endmodule
